// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: consumes EX/MEM pipeline outputs, runs data-memory
// loads/stores over a req/ack handshake, stalls upstream while an access is
// outstanding and registers the MEM/WB stage outputs.
module mem_stage_ctrl #(
  parameter int ARQ     = 16,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wb_enable_in,
  input  logic           rd_mem_en,
  input  logic           wr_mem_en,
  input  logic           mux_mem_in,
  input  logic           pc_en_in,
  input  logic [ARQ-1:0] src1_in,
  input  logic [ARQ-1:0] srcdest_in,
  input  logic [ARQ-1:0] alu_result_in,
  input  logic [ARQ-1:0] wb_imm_in,
  input  logic [2:0]     wb_dest_in,
  output logic           mem_req,
  output logic           mem_we,
  output logic [ARQ-1:0] mem_addr,
  output logic [ARQ-1:0] mem_wdata,
  input  logic [ARQ-1:0] mem_rdata,
  input  logic           mem_ack,
  output logic           stall_out,
  output logic           mem_err,
  output logic           wb_enable_out,
  output logic           pc_en_out,
  output logic [ARQ-1:0] src1_out,
  output logic [ARQ-1:0] wb_data_out,
  output logic [ARQ-1:0] wb_imm_out,
  output logic [2:0]     wb_dest_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Last counter value before the access is abandoned (counter starts at 0).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]     state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [ARQ-1:0] mem_addr_q, mem_addr_d;
  logic [ARQ-1:0] mem_wdata_q, mem_wdata_d;
  logic           mem_err_q, mem_err_d;
  logic           wb_enable_q, wb_enable_d;
  logic           pc_en_q, pc_en_d;
  logic [ARQ-1:0] src1_q, src1_d;
  logic [ARQ-1:0] wb_data_q, wb_data_d;
  logic [ARQ-1:0] wb_imm_q, wb_imm_d;
  logic [2:0]     wb_dest_q, wb_dest_d;
  logic           stall_d;
  logic           access;
  logic           is_load;

  // Next-state, handshake and MEM/WB update logic; stall is purely combinational.
  always_comb begin
    access      = rd_mem_en | wr_mem_en;
    // A simultaneous load+store request is treated as a store.
    is_load     = rd_mem_en & ~wr_mem_en;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = mem_err_q;
    wb_enable_d = wb_enable_q;
    pc_en_d     = pc_en_q;
    src1_d      = src1_q;
    wb_data_d   = wb_data_q;
    wb_imm_d    = wb_imm_q;
    wb_dest_d   = wb_dest_q;
    stall_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          stall_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = wr_mem_en;
          mem_addr_d  = alu_result_in;
          mem_wdata_d = srcdest_in;
          cnt_d       = 8'd0;
          state_d     = WAIT;
          wb_enable_d = 1'b0;
          pc_en_d     = 1'b0;
        end else begin
          // No load in flight, so mux_mem_in has nothing to select.
          wb_enable_d = wb_enable_in;
          pc_en_d     = pc_en_in;
          src1_d      = src1_in;
          wb_data_d   = alu_result_in;
          wb_imm_d    = wb_imm_in;
          wb_dest_d   = wb_dest_in;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          // Ack takes priority over a timeout landing in the same cycle.
          mem_req_d   = 1'b0;
          state_d     = IDLE;
          wb_enable_d = wb_enable_in;
          pc_en_d     = pc_en_in;
          src1_d      = src1_in;
          wb_data_d   = (is_load && mux_mem_in) ? mem_rdata : alu_result_in;
          wb_imm_d    = wb_imm_in;
          wb_dest_d   = wb_dest_in;
        end else if (cnt_q == CNT_LAST) begin
          // Give up: flag the error and drop the instruction as a bubble.
          mem_req_d   = 1'b0;
          mem_err_d   = 1'b1;
          state_d     = IDLE;
          wb_enable_d = 1'b0;
          pc_en_d     = 1'b0;
        end else begin
          stall_d     = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          wb_enable_d = 1'b0;
          pc_en_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset of everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
      wb_enable_q <= 1'b0;
      pc_en_q     <= 1'b0;
      src1_q      <= '0;
      wb_data_q   <= '0;
      wb_imm_q    <= '0;
      wb_dest_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
      wb_enable_q <= wb_enable_d;
      pc_en_q     <= pc_en_d;
      src1_q      <= src1_d;
      wb_data_q   <= wb_data_d;
      wb_imm_q    <= wb_imm_d;
      wb_dest_q   <= wb_dest_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_err       = mem_err_q;
  assign stall_out     = stall_d;
  assign wb_enable_out = wb_enable_q;
  assign pc_en_out     = pc_en_q;
  assign src1_out      = src1_q;
  assign wb_data_out   = wb_data_q;
  assign wb_imm_out    = wb_imm_q;
  assign wb_dest_out   = wb_dest_q;

endmodule
